// File: rtl/collision_pkg.sv
// collision_pkg
//   Shared definitions for the collision scheduler slice: coordinate and
//   score widths, the default hit-box half-size and the one-hot FSM encoding.
package collision_pkg;

  localparam int COORD_W            = 10;
  localparam int SCORE_W            = 16;
  localparam int DEFAULT_HIT_RADIUS = 25;

  // One-hot scheduler states.
  typedef enum logic [3:0] {
    INIT = 4'b0001,
    IDLE = 4'b0010,
    SCAN = 4'b0100,
    HIT  = 4'b1000
  } state_e;

endpackage

// File: rtl/collision_scheduler_hit_box_compare.sv
// hit_box_compare
//   Combinational square hit-box test between one enemy and the projectile.
//   Ports:
//     enemy_h, enemy_v           enemy centre
//     projectile_h, projectile_v projectile position
//     radius                     half-size of the square box
//     overlap                    projectile lies inside the box (inclusive)
module hit_box_compare
  import collision_pkg::*;
(
  input  logic [COORD_W-1:0] enemy_h,
  input  logic [COORD_W-1:0] enemy_v,
  input  logic [COORD_W-1:0] projectile_h,
  input  logic [COORD_W-1:0] projectile_v,
  input  logic [COORD_W-1:0] radius,
  output logic               overlap
);

  // Bounds carry one extra bit so the upper edge never wraps near the
  // right/bottom of the screen; the lower edge clamps at zero.
  logic [COORD_W:0] lo_h, hi_h, lo_v, hi_v;
  logic [COORD_W:0] ph_ext, pv_ext;

  assign lo_h   = (enemy_h < radius) ? '0 : ({1'b0, enemy_h} - {1'b0, radius});
  assign hi_h   = {1'b0, enemy_h} + {1'b0, radius};
  assign lo_v   = (enemy_v < radius) ? '0 : ({1'b0, enemy_v} - {1'b0, radius});
  assign hi_v   = {1'b0, enemy_v} + {1'b0, radius};
  assign ph_ext = {1'b0, projectile_h};
  assign pv_ext = {1'b0, projectile_v};

  assign overlap = (ph_ext >= lo_h) && (ph_ext <= hi_h) &&
                   (pv_ext >= lo_v) && (pv_ext <= hi_v);

endmodule

// File: rtl/collision_scheduler.sv
// collision_scheduler
//   Scans one enemy slot per clock against a latched projectile after each
//   frame tick, using a single shared hit-box comparator. Owns the alive
//   mask, kill score and wave-clear status.
//   Ports:
//     clk, reset          clock, asynchronous active-high reset
//     start               pulse: begin a new wave (highest priority)
//     frame_tick          pulse: request a scan (honoured only in IDLE)
//     projectile_active   projectile in flight
//     projectile_h/_v     projectile position (latched at scan start)
//     enemy_h/v_flat      packed enemy positions, slot i at [10*i+9:10*i]
//     alive_mask          bit i = slot i alive
//     hit_pulse           one-cycle kill pulse
//     hit_index           slot killed (held between kills)
//     projectile_consume  one-cycle pulse with hit_pulse
//     score               saturating kill count since start
//     wave_clear          all slots dead
//     busy                scanning or reporting a hit
module collision_scheduler
  import collision_pkg::*;
#(
  parameter int NUM_ENEMIES = 8,
  parameter int IDX_W       = 3,
  parameter int HIT_RADIUS  = DEFAULT_HIT_RADIUS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           frame_tick,
  input  logic                           projectile_active,
  input  logic [COORD_W-1:0]             projectile_h,
  input  logic [COORD_W-1:0]             projectile_v,
  input  logic [COORD_W*NUM_ENEMIES-1:0] enemy_h_flat,
  input  logic [COORD_W*NUM_ENEMIES-1:0] enemy_v_flat,
  output logic [NUM_ENEMIES-1:0]         alive_mask,
  output logic                           hit_pulse,
  output logic [IDX_W-1:0]               hit_index,
  output logic                           projectile_consume,
  output logic [SCORE_W-1:0]             score,
  output logic                           wave_clear,
  output logic                           busy
);

  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_ENEMIES - 1);
  localparam logic [COORD_W-1:0] RADIUS   = COORD_W'(HIT_RADIUS);

  state_e                   state_q, state_d;
  logic [NUM_ENEMIES-1:0]   alive_q, alive_d;
  logic [SCORE_W-1:0]       score_q, score_d;
  logic                     wave_clear_q, wave_clear_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [IDX_W-1:0]         hit_index_q, hit_index_d;
  logic [COORD_W-1:0]       ph_q, ph_d, pv_q, pv_d;

  // Unpack the flat position buses so the slot mux is a plain array read.
  logic [COORD_W-1:0] enemy_h_arr [NUM_ENEMIES];
  logic [COORD_W-1:0] enemy_v_arr [NUM_ENEMIES];

  for (genvar gi = 0; gi < NUM_ENEMIES; gi++) begin : g_unpack
    assign enemy_h_arr[gi] = enemy_h_flat[COORD_W*gi +: COORD_W];
    assign enemy_v_arr[gi] = enemy_v_flat[COORD_W*gi +: COORD_W];
  end

  logic [COORD_W-1:0] cmp_h, cmp_v;
  logic               overlap;

  // Enemy position of the slot under test is taken live from the inputs.
  assign cmp_h = enemy_h_arr[idx_q];
  assign cmp_v = enemy_v_arr[idx_q];

  hit_box_compare u_cmp (
    .enemy_h      (cmp_h),
    .enemy_v      (cmp_v),
    .projectile_h (ph_q),
    .projectile_v (pv_q),
    .radius       (RADIUS),
    .overlap      (overlap)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= INIT;
      alive_q      <= '0;
      score_q      <= '0;
      wave_clear_q <= 1'b0;
      idx_q        <= '0;
      hit_index_q  <= '0;
      ph_q         <= '0;
      pv_q         <= '0;
    end else begin
      state_q      <= state_d;
      alive_q      <= alive_d;
      score_q      <= score_d;
      wave_clear_q <= wave_clear_d;
      idx_q        <= idx_d;
      hit_index_q  <= hit_index_d;
      ph_q         <= ph_d;
      pv_q         <= pv_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    alive_d      = alive_q;
    score_d      = score_q;
    wave_clear_d = wave_clear_q;
    idx_d        = idx_q;
    hit_index_d  = hit_index_q;
    ph_d         = ph_q;
    pv_d         = pv_q;

    if (start) begin
      // Abort whatever is in flight; nothing else changes until INIT runs.
      state_d = INIT;
    end else begin
      unique case (state_q)
        INIT: begin
          alive_d      = '1;
          score_d      = '0;
          wave_clear_d = 1'b0;
          state_d      = IDLE;
        end
        IDLE: begin
          if (frame_tick && projectile_active && !wave_clear_q) begin
            ph_d    = projectile_h;
            pv_d    = projectile_v;
            idx_d   = '0;
            state_d = SCAN;
          end
        end
        SCAN: begin
          if (alive_q[idx_q] && overlap) begin
            hit_index_d = idx_q;
            state_d     = HIT;
          end else if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        HIT: begin
          alive_d[hit_index_q] = 1'b0;
          if (score_q != '1) begin
            score_d = score_q + 1'b1;
          end
          // Registered here so wave_clear is already high in the first IDLE
          // cycle after the final kill.
          wave_clear_d = (alive_d == '0);
          state_d      = IDLE;
        end
        default: state_d = INIT;
      endcase
    end
  end

  assign alive_mask         = alive_q;
  assign score              = score_q;
  assign wave_clear         = wave_clear_q;
  assign hit_index          = hit_index_q;
  assign hit_pulse          = (state_q == HIT);
  assign projectile_consume = (state_q == HIT);
  assign busy               = (state_q == SCAN) || (state_q == HIT);

endmodule
